// File: rtl/ysyx_24080014_axi_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the SRAM responder.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ysyx_24080014_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

endpackage

// File: rtl/ysyx_24080014_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to jitter the SRAM access latency.
// Latency: steps every cycle; reset loads seed 8'hA5.
// Backpressure: none, free-running.
module ysyx_24080014_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] out
);

  // Shift left, feeding back the XOR of taps 8,6,5,4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= 8'hA5;
    else     out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
  end

endmodule

// File: rtl/ysyx_24080014_axil_sram.sv
// AXI4-Lite word-addressed SRAM model with independent read and write channels.
// Latency: rvalid READ_LAT cycles after AR handshake; bvalid WRITE_LAT cycles after later AW/W handshake.
// Backpressure: one outstanding read and write; ready drops until the response is accepted.
// Optional jitter macro: YSYX_24080014_SRAM_RAND_DELAY_EN adds 0..3 cycles per access from an LFSR.
module ysyx_24080014_axil_sram
  import ysyx_24080014_axi_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  logic [31:0] mem [0:DEPTH-1];

  // Extra latency cycles; constant zero unless jitter is enabled.
  logic [1:0] extra;
`ifdef YSYX_24080014_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  ysyx_24080014_lfsr8 u_lfsr (.clk(clk), .rst(rst), .out(lfsr));
  assign extra = lfsr[1:0];
`else
  assign extra = 2'b00;
`endif

  // ---------------- read channel ----------------
  rd_state_t   rstate, rstate_nxt;
  logic [15:0] rcnt;
  logic [31:0] raddr_q, r_off;
  logic        r_ok;

  assign r_off = raddr_q - BASE;
  assign r_ok  = r_off < SPAN;

  // Read state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rstate <= R_IDLE;
    else     rstate <= rstate_nxt;
  end

  // Read next-state and handshake outputs.
  always_comb begin
    rstate_nxt = rstate;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (rstate)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) rstate_nxt = R_WAIT;
      end
      R_WAIT: if (rcnt == '0) rstate_nxt = R_RESP;
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // Latch the address, count down, then capture data so it holds through R_RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt    <= '0;
      raddr_q <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else if (rstate == R_IDLE && arvalid) begin
      raddr_q <= araddr;
      rcnt    <= 16'(READ_LAT - 1) + 16'(extra);
    end else if (rstate == R_WAIT) begin
      if (rcnt == '0) begin
        rdata <= r_ok ? mem[r_off[AW+1:2]] : 32'h0;
        rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        rcnt <= rcnt - 16'd1;
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_t   wstate, wstate_nxt;
  logic [15:0] wcnt;
  logic        aw_held, w_held, do_write, w_ok;
  logic [31:0] awaddr_q, wdata_q, waddr_eff, wdata_eff, w_off;
  logic [3:0]  wstrb_q, wstrb_eff;

  // A channel that handshakes in the same cycle as the write uses its live bus.
  assign waddr_eff = aw_held ? awaddr_q : awaddr;
  assign wdata_eff = w_held  ? wdata_q  : wdata;
  assign wstrb_eff = w_held  ? wstrb_q  : wstrb;
  assign w_off     = waddr_eff - BASE;
  assign w_ok      = w_off < SPAN;

  // Write state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wstate <= W_IDLE;
    else     wstate <= wstate_nxt;
  end

  // Write next-state: commit once both AW and W are held or handshaking now.
  always_comb begin
    wstate_nxt = wstate;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    do_write   = 1'b0;
    case (wstate)
      W_IDLE: begin
        awready = ~aw_held;
        wready  = ~w_held;
        if ((aw_held | awvalid) && (w_held | wvalid)) begin
          do_write   = 1'b1;
          wstate_nxt = W_WAIT;
        end
      end
      W_WAIT: if (wcnt == '0) wstate_nxt = W_RESP;
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // Hold AW/W independently, then load the latency count and response on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wcnt     <= '0;
      bresp    <= RESP_OKAY;
    end else if (wstate == W_IDLE) begin
      if (!aw_held && awvalid) begin
        aw_held  <= 1'b1;
        awaddr_q <= awaddr;
      end
      if (!w_held && wvalid) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (do_write) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        wcnt    <= 16'(WRITE_LAT - 1) + 16'(extra);
        bresp   <= w_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end else if (wstate == W_WAIT && wcnt != '0) begin
      wcnt <= wcnt - 16'd1;
    end
  end

  // Byte-lane memory update; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (!rst && do_write && w_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_eff[b]) mem[w_off[AW+1:2]][8*b +: 8] <= wdata_eff[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_axil_sram.sv
module tb_ysyx_24080014_axil_sram;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int RL = 2;
  localparam int WL = 3;
`ifdef YSYX_24080014_SRAM_RAND_DELAY_EN
  localparam int JIT = 3;
`else
  localparam int JIT = 0;
`endif

  logic        clk = 0, rst = 1;
  logic [31:0] araddr = 0, awaddr = 0, wdata = 0, rdata;
  logic        arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
  logic [3:0]  wstrb = 0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [1:0]  rresp, bresp;

  int checks = 0, errors = 0;
  logic [33:0] rd_exp_q[$];
  logic [1:0]  wr_exp_q[$];
  logic [31:0] model [int];

  always #5 clk = ~clk;

  ysyx_24080014_axil_sram #(.DEPTH(DEPTH), .BASE(BASE), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready));

  function automatic bit in_range(input logic [31:0] a);
    logic [63:0] a64, lo, hi;
    a64 = {32'h0, a};
    lo  = {32'h0, BASE};
    hi  = lo + 64'(4 * DEPTH);
    return (a64 >= lo) && (a64 < hi);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Drives one write (W leads AW by w_lead cycles), pushes the expected response.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, output logic [1:0] resp, output int lat, output bit to);
    int cyc, hs;
    bit aw_done, w_done, aw_fire, w_fire;
    logic [31:0] old;
    cyc = 0; hs = -1; aw_done = 0; w_done = 0; to = 1; lat = -1; resp = 2'b11;
    @(negedge clk);
    wvalid = 1; wdata = data; wstrb = strb;
    if (w_lead == 0) begin awvalid = 1; awaddr = addr; end
    if (in_range(addr)) begin
      old = model.exists(widx(addr)) ? model[widx(addr)] : 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) old[8*b +: 8] = data[8*b +: 8];
      model[widx(addr)] = old;
      wr_exp_q.push_back(2'b00);
    end else begin
      wr_exp_q.push_back(2'b10);
    end
    for (int i = 0; i < 60; i++) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk); cyc++;
      if (aw_fire) begin awvalid = 0; aw_done = 1; end
      if (w_fire)  begin wvalid = 0;  w_done = 1;  end
      if (aw_done && w_done && hs < 0) hs = cyc;
      if (bvalid && hs >= 0) begin lat = cyc - hs; resp = bresp; to = 0; break; end
      if (!aw_done && !awvalid && cyc >= w_lead) begin awvalid = 1; awaddr = addr; end
    end
    awvalid = 0; wvalid = 0;
    bready = 1; @(negedge clk); bready = 0;
  endtask

  // Drives one read, pushes the model's expected {resp,data}, returns what the DUT gave.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output int lat, output bit to);
    int cyc, hs;
    bit fire;
    cyc = 0; hs = -1; to = 1; lat = -1; data = 'x; resp = 2'b11;
    @(negedge clk);
    arvalid = 1; araddr = addr;
    if (in_range(addr)) rd_exp_q.push_back({2'b00, model.exists(widx(addr)) ? model[widx(addr)] : 32'h0});
    else                rd_exp_q.push_back({2'b10, 32'h0});
    for (int i = 0; i < 60; i++) begin
      fire = arvalid && arready;
      @(negedge clk); cyc++;
      if (fire) begin arvalid = 0; hs = cyc; end
      if (rvalid && hs >= 0) begin lat = cyc - hs; data = rdata; resp = rresp; to = 0; break; end
    end
    arvalid = 0;
    rready = 1; @(negedge clk); rready = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (rvalid !== 0 || bvalid !== 0 || rdata !== 0 || rresp !== 0 || bresp !== 0) begin
      errors++; $display("FAIL reset_outputs: rvalid=%b bvalid=%b rdata=%h rresp=%b bresp=%b, want 0", rvalid, bvalid, rdata, rresp, bresp);
    end
    checks++;
    if (arready !== 1 || awready !== 1 || wready !== 1) begin
      errors++; $display("FAIL reset_readies: ar=%b aw=%b w=%b, want 111", arready, awready, wready);
    end
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic [1:0] r; int lat; bit to; logic [33:0] e;
    axi_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, r, lat, to);
    e[1:0] = wr_exp_q.pop_front();
    checks++;
    if (to || r !== e[1:0]) begin errors++; $display("FAIL wr_bresp: got %b to=%0d want %b", r, to, e[1:0]); end
    axi_read(BASE + 32'h10, d, r, lat, to);
    e = rd_exp_q.pop_front();
    checks++;
    if (to || {r, d} !== e || d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %b/%h want %b/%h", r, d, e[33:32], e[31:0]); end
    checks++;
    if (lat < RL || lat > RL + JIT) begin errors++; $display("FAIL rd_latency: got %0d want %0d..%0d", lat, RL, RL + JIT); end
  endtask

  task automatic test_read_stall();
    logic [33:0] e; bit seen;
    seen = 0;
    @(negedge clk);
    arvalid = 1; araddr = BASE + 32'h10;
    rd_exp_q.push_back({2'b00, model[widx(BASE + 32'h10)]});
    @(negedge clk); arvalid = 0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = rvalid; end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_rvalid_timeout: rvalid=%b want 1", rvalid); end
    e = rd_exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rvalid !== 1 || rdata !== e[31:0] || rresp !== e[33:32] || arready !== 0) begin
        errors++; $display("FAIL stall_hold%0d: rvalid=%b rdata=%h arready=%b want 1 %h 0", i, rvalid, rdata, arready, e[31:0]);
      end
      @(negedge clk);
    end
    rready = 1;
    checks++;
    if (arready !== 0) begin errors++; $display("FAIL stall_arready_pre: got %b want 0", arready); end
    @(negedge clk); rready = 0;
    checks++;
    if (arready !== 1 || rvalid !== 0) begin errors++; $display("FAIL stall_post: arready=%b rvalid=%b want 1 0", arready, rvalid); end
  endtask

  task automatic test_write_orders();
    logic [31:0] d; logic [1:0] r; int lat; bit to; logic [33:0] e;
    axi_write(BASE + 32'h20, 32'hA5A5_0001, 4'hF, 2, r, lat, to);
    e[1:0] = wr_exp_q.pop_front();
    checks++;
    if (to || r !== e[1:0] || lat < WL || lat > WL + JIT) begin
      errors++; $display("FAIL w_first: bresp=%b lat=%0d to=%0d want %b lat %0d..%0d", r, lat, to, e[1:0], WL, WL + JIT);
    end
    axi_write(BASE + 32'h24, 32'h5A5A_0002, 4'hF, 0, r, lat, to);
    e[1:0] = wr_exp_q.pop_front();
    checks++;
    if (to || r !== e[1:0] || lat < WL || lat > WL + JIT) begin
      errors++; $display("FAIL same_cycle: bresp=%b lat=%0d to=%0d want %b lat %0d..%0d", r, lat, to, e[1:0], WL, WL + JIT);
    end
    checks++;
    if (bvalid !== 0 || awready !== 1 || wready !== 1) begin errors++; $display("FAIL b_done: bvalid=%b aw=%b w=%b want 0 1 1", bvalid, awready, wready); end
    for (int k = 0; k < 2; k++) begin
      axi_read(BASE + 32'h20 + 32'(4 * k), d, r, lat, to);
      e = rd_exp_q.pop_front();
      checks++;
      if (to || {r, d} !== e) begin errors++; $display("FAIL order_rb%0d: got %b/%h want %b/%h", k, r, d, e[33:32], e[31:0]); end
    end
  endtask

  task automatic test_wstrb();
    logic [31:0] d; logic [1:0] r; int lat; bit to; logic [33:0] e;
    axi_write(BASE + 32'h40, 32'hFFFFFFFF, 4'hF, 0, r, lat, to);
    void'(wr_exp_q.pop_front());
    axi_write(BASE + 32'h40, 32'h11223344, 4'b0101, 1, r, lat, to);
    e[1:0] = wr_exp_q.pop_front();
    checks++;
    if (to || r !== e[1:0]) begin errors++; $display("FAIL strb_bresp: got %b want %b", r, e[1:0]); end
    axi_read(BASE + 32'h40, d, r, lat, to);
    e = rd_exp_q.pop_front();
    checks++;
    if (to || {r, d} !== e || d !== 32'hFF22FF44) begin errors++; $display("FAIL strb_rb: got %h want %h", d, e[31:0]); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat; bit to; logic [33:0] e;
    axi_write(BASE + 32'(4 * (DEPTH - 1)), 32'hCAFEF00D, 4'hF, 0, r, lat, to);
    void'(wr_exp_q.pop_front());
    axi_read(32'h7000_0000, d, r, lat, to);
    e = rd_exp_q.pop_front();
    checks++;
    if (to || {r, d} !== e || r !== 2'b10) begin errors++; $display("FAIL oor_read: got %b/%h want %b/%h", r, d, e[33:32], e[31:0]); end
    axi_write(BASE + 32'(4 * DEPTH), 32'h12345678, 4'hF, 0, r, lat, to);
    e[1:0] = wr_exp_q.pop_front();
    checks++;
    if (to || r !== e[1:0] || r !== 2'b10) begin errors++; $display("FAIL oor_write: got %b want %b", r, e[1:0]); end
    axi_read(BASE + 32'(4 * (DEPTH - 1)), d, r, lat, to);
    e = rd_exp_q.pop_front();
    checks++;
    if (to || {r, d} !== e) begin errors++; $display("FAIL oor_neighbour: got %h want %h", d, e[31:0]); end
  endtask

  task automatic test_reset_midread();
    logic [31:0] d; logic [1:0] r; int lat; bit to; logic [33:0] e;
    @(negedge clk);
    arvalid = 1; araddr = BASE + 32'h10;
    @(negedge clk); arvalid = 0;
    checks++;
    if (arready !== 0 || rvalid !== 0) begin errors++; $display("FAIL midread_wait: arready=%b rvalid=%b want 0 0", arready, rvalid); end
    #2 rst = 1;
    #1;
    checks++;
    if (rvalid !== 0 || arready !== 1) begin errors++; $display("FAIL midread_rst: rvalid=%b arready=%b want 0 1", rvalid, arready); end
    @(negedge clk); rst = 0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    checks++;
    if (rvalid !== 0) begin errors++; $display("FAIL midread_dropped: rvalid=%b want 0", rvalid); end
    axi_read(BASE + 32'h10, d, r, lat, to);
    e = rd_exp_q.pop_front();
    checks++;
    if (to || {r, d} !== e) begin errors++; $display("FAIL midread_after: got %b/%h want %b/%h", r, d, e[33:32], e[31:0]); end
  endtask

`ifdef YSYX_24080014_SRAM_RAND_DELAY_EN
  task automatic test_rand_latency();
    logic [31:0] d; logic [1:0] r; int lat; bit to; logic [33:0] e;
    for (int i = 0; i < 100; i++) begin
      axi_read(BASE + 32'h10, d, r, lat, to);
      e = rd_exp_q.pop_front();
      checks++;
      if (to || {r, d} !== e || lat < RL || lat > RL + 3) begin
        errors++; $display("FAIL rand_lat%0d: lat=%0d data=%h want %0d..%0d %h", i, lat, d, RL, RL + 3, e[31:0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_read_stall();
    test_write_orders();
    test_wstrb();
    test_out_of_range();
    test_reset_midread();
`ifdef YSYX_24080014_SRAM_RAND_DELAY_EN
    test_rand_latency();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
